// File: rtl/multiplay_mouse_acc_if.sv
// Bus between the HPS ps2_mouse feed, the I/O decode and the mouse accumulator.
interface multiplay_mouse_acc_if;
   logic [24:0] ps2_mouse;
   logic        sel;
   logic [2:0]  addr;
   logic [7:0]  dout;

   modport master (output ps2_mouse, output sel, output addr, input dout);
   modport slave  (input ps2_mouse, input sel, input addr, output dout);
endinterface

// File: rtl/multiplay_mouse_acc.sv
// Accumulating PS/2 mouse controller: integrates packets into saturating X/Y
// accumulators and hands out nibble-clamped deltas, draining only what was read.
module multiplay_mouse_acc #(
   parameter int ACC_W    = 12,
   parameter int STEP_MAX = 7
) (
   input logic                  clk_sys,
   input logic                  reset,
   multiplay_mouse_acc_if.slave bus
);

   // Extended width: holds acc +/- a 9-bit delta and a step without overflow.
   localparam int EW = ACC_W + 10;
   localparam logic signed [EW-1:0] ACC_MAX = {{11{1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [EW-1:0] ACC_MIN = {{11{1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [EW-1:0] STEP_HI = EW'(STEP_MAX);
   localparam logic signed [EW-1:0] STEP_LO = EW'(-(STEP_MAX + 1));

   logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
   logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
   logic [2:0]              btn_q, btn_d;
   logic                    ovf_q, ovf_d;
   logic [7:0]              dout_q, dout_d;
   logic                    old_sel_q, old_sel_d;
   logic                    old_status_q, old_status_d;
   logic                    primed_q, primed_d;

   logic                    pkt_evt, rd_evt, rd_x, rd_y;
   logic signed [8:0]       dx9, dy9;
   logic signed [EW-1:0]    dx_e, dy_e, ext_x, ext_y, take_x, take_y, sum_x, sum_y;
   logic                    clip_x, clip_y;
   logic                    unused_ps2;

   assign unused_ps2 = &{1'b0, bus.ps2_mouse[7:6], bus.ps2_mouse[3]};
   assign bus.dout   = dout_q;

   function automatic logic signed [EW-1:0] clamp_step(input logic signed [EW-1:0] v);
      if (v > STEP_HI)      return STEP_HI;
      else if (v < STEP_LO) return STEP_LO;
      else                  return v;
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] s;
      if (v > ACC_MAX)      s = ACC_MAX;
      else if (v < ACC_MIN) s = ACC_MIN;
      else                  s = v;
      return s[ACC_W-1:0];
   endfunction

   // Event detection, per-axis take/accumulate, register map and next-state.
   always_comb begin
      pkt_evt      = primed_q && (bus.ps2_mouse[24] != old_status_q);
      rd_evt       = !old_sel_q && bus.sel;
      rd_x         = rd_evt && (bus.addr == 3'd2);
      rd_y         = rd_evt && (bus.addr == 3'd3);

      dx9          = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
      dy9          = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
      dx_e         = dx9;
      dy_e         = dy9;
      dy_e         = -dy_e;

      ext_x        = acc_x_q;
      ext_y        = acc_y_q;
      take_x       = clamp_step(ext_x);
      take_y       = clamp_step(ext_y);

      // Take comes from the pre-update value; the packet delta lands on top.
      sum_x        = ext_x;
      sum_y        = ext_y;
      if (rd_x)    sum_x = sum_x - take_x;
      if (rd_y)    sum_y = sum_y - take_y;
      if (pkt_evt) begin
         sum_x     = sum_x + dx_e;
         sum_y     = sum_y + dy_e;
      end
      clip_x       = (sum_x > ACC_MAX) || (sum_x < ACC_MIN);
      clip_y       = (sum_y > ACC_MAX) || (sum_y < ACC_MIN);
      acc_x_d      = sat_acc(sum_x);
      acc_y_d      = sat_acc(sum_y);

      btn_d        = pkt_evt ? bus.ps2_mouse[2:0] : btn_q;
      // A clip on this clock wins over the status-read clear.
      ovf_d        = (ovf_q && !(rd_evt && (bus.addr == 3'd1))) || clip_x || clip_y;

      old_sel_d    = bus.sel;
      old_status_d = bus.ps2_mouse[24];
      primed_d     = 1'b1;

      dout_d       = dout_q;
      if (!bus.sel) begin
         dout_d    = 8'hFF;
      end else if (rd_evt) begin
         case (bus.addr)
            3'd0:    dout_d = {1'b0, btn_q, 4'b0000};
            3'd1:    dout_d = {5'b0, ovf_q, acc_y_q != '0, acc_x_q != '0};
            3'd2:    dout_d = take_x[7:0];
            3'd3:    dout_d = take_y[7:0];
            default: dout_d = 8'hFF;
         endcase
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         acc_x_q      <= '0;
         acc_y_q      <= '0;
         btn_q        <= '0;
         ovf_q        <= 1'b0;
         dout_q       <= 8'hFF;
         old_sel_q    <= 1'b0;
         old_status_q <= 1'b0;
         primed_q     <= 1'b0;
      end else begin
         acc_x_q      <= acc_x_d;
         acc_y_q      <= acc_y_d;
         btn_q        <= btn_d;
         ovf_q        <= ovf_d;
         dout_q       <= dout_d;
         old_sel_q    <= old_sel_d;
         old_status_q <= old_status_d;
         primed_q     <= primed_d;
      end
   end

endmodule

// File: tb/tb_multiplay_mouse_acc.sv
// Self-checking bench for multiplay_mouse_acc against an integer reference model.
module tb_multiplay_mouse_acc;

   localparam int ACC_W    = 12;
   localparam int STEP_MAX = 7;
   localparam int A_MAX    = (1 << (ACC_W - 1)) - 1;
   localparam int A_MIN    = -(1 << (ACC_W - 1));

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   // Reference model state
   int m_x, m_y, m_btn;
   bit m_ovf;

   multiplay_mouse_acc_if bus ();

   multiplay_mouse_acc #(.ACC_W(ACC_W), .STEP_MAX(STEP_MAX)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic int s9(input logic [8:0] v);
      return v[8] ? int'(v[7:0]) - 256 : int'(v[7:0]);
   endfunction

   function automatic int clampi(input int v);
      if (v > STEP_MAX) return STEP_MAX;
      if (v < -(STEP_MAX + 1)) return -(STEP_MAX + 1);
      return v;
   endfunction

   // One clock of the model; returns the expected read byte (or -1 with no read).
   function automatic int model_cycle(input bit pkt, input int dx, input int dy, input int b,
                                      input bit rd, input int a);
      int exp, tx, ty, nx, ny;
      bit clr, clip;
      exp = -1; tx = 0; ty = 0; clr = 0; clip = 0;
      if (rd) begin
         case (a)
            0: exp = m_btn * 16;
            1: begin exp = (m_ovf ? 4 : 0) + (m_y != 0 ? 2 : 0) + (m_x != 0 ? 1 : 0); clr = 1; end
            2: begin tx = clampi(m_x); exp = tx & 255; end
            3: begin ty = clampi(m_y); exp = ty & 255; end
            default: exp = 255;
         endcase
      end
      nx = m_x - tx + (pkt ? dx : 0);
      ny = m_y - ty + (pkt ? dy : 0);
      if (nx > A_MAX) begin nx = A_MAX; clip = 1; end
      if (nx < A_MIN) begin nx = A_MIN; clip = 1; end
      if (ny > A_MAX) begin ny = A_MAX; clip = 1; end
      if (ny < A_MIN) begin ny = A_MIN; clip = 1; end
      m_x = nx; m_y = ny;
      m_ovf = (m_ovf && !clr) || clip;
      if (pkt) m_btn = b;
      return exp;
   endfunction

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.sel = 1'b0;
      bus.addr = 3'd0;
      repeat (2) step();
      reset = 1'b0;
      step();   // priming clock
      m_x = 0; m_y = 0; m_btn = 0; m_ovf = 0;
   endtask

   task automatic put_pkt(input logic [8:0] x9, input logic [8:0] y9, input logic [2:0] b);
      bus.ps2_mouse[15:8]  = x9[7:0];
      bus.ps2_mouse[4]     = x9[8];
      bus.ps2_mouse[23:16] = y9[7:0];
      bus.ps2_mouse[5]     = y9[8];
      bus.ps2_mouse[2:0]   = b;
      bus.ps2_mouse[7:6]   = 2'($urandom);
      bus.ps2_mouse[3]     = 1'($urandom);
      bus.ps2_mouse[24]    = ~bus.ps2_mouse[24];
   endtask

   task automatic send_pkt(input logic [8:0] x9, input logic [8:0] y9, input logic [2:0] b);
      int unused_r;
      put_pkt(x9, y9, b);
      step();
      unused_r = model_cycle(1, s9(x9), -s9(y9), int'(b), 0, 0);
   endtask

   // Packet (optional) and a read on the same clock; sel drops afterwards.
   task automatic read_cyc(input bit pkt, input logic [8:0] x9, input logic [8:0] y9,
                           input logic [2:0] b, input int a,
                           output logic [7:0] got, output logic [7:0] exp);
      if (pkt) put_pkt(x9, y9, b);
      bus.sel  = 1'b1;
      bus.addr = 3'(a);
      step();
      got = bus.dout;
      exp = 8'(model_cycle(pkt, s9(x9), -s9(y9), int'(b), 1, a));
      bus.sel = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [7:0] g, e;
      bus.ps2_mouse = 25'h1000000;
      do_reset();
      repeat (2) step();
      checks++;
      if (bus.dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got=%h exp=ff", bus.dout); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h00) begin errors++; $display("FAIL reset_rd2 got=%h exp=00", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 1, g, e);
      checks++;
      if (g !== 8'h00) begin errors++; $display("FAIL reset_rd1 got=%h exp=00", g); end
   endtask

   task automatic test_drain();
      logic [7:0] g, e;
      logic [7:0] seq [4] = '{8'h07, 8'h07, 8'h06, 8'h00};
      do_reset();
      send_pkt(9'h014, 9'h000, 3'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 2 || i == 3) begin
            read_cyc(0, 9'd0, 9'd0, 3'd0, 1, g, e);
            checks++;
            if (g[0] !== (i == 2 ? 1'b1 : 1'b0))
               begin errors++; $display("FAIL drain_stat%0d got=%h", i, g); end
         end
         read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
         checks++;
         if (g !== seq[i]) begin errors++; $display("FAIL drain_rd%0d got=%h exp=%h", i, g, seq[i]); end
      end
   endtask

   task automatic test_y();
      logic [7:0] g, e;
      do_reset();
      send_pkt(9'h000, 9'h005, 3'd0);
      read_cyc(0, 9'd0, 9'd0, 3'd0, 3, g, e);
      checks++;
      if (g !== 8'hFB) begin errors++; $display("FAIL y_rd1 got=%h exp=fb", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 3, g, e);
      checks++;
      if (g !== 8'h00) begin errors++; $display("FAIL y_rd2 got=%h exp=00", g); end
   endtask

   task automatic test_same_clock();
      logic [7:0] g, e;
      do_reset();
      send_pkt(9'h00A, 9'h000, 3'd0);
      read_cyc(1, 9'h1FD, 9'h000, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h07) begin errors++; $display("FAIL same_rd got=%h exp=07", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h00) begin errors++; $display("FAIL same_next got=%h exp=00", g); end
   endtask

   task automatic test_saturate();
      logic [7:0] g, e;
      do_reset();
      for (int i = 0; i < 20; i++) send_pkt(9'h0FF, 9'h000, 3'd0);
      read_cyc(0, 9'd0, 9'd0, 3'd0, 1, g, e);
      checks++;
      if (g !== 8'h05) begin errors++; $display("FAIL sat_stat1 got=%h exp=05", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 1, g, e);
      checks++;
      if (g !== 8'h01) begin errors++; $display("FAIL sat_stat2 got=%h exp=01", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h07) begin errors++; $display("FAIL sat_rd got=%h exp=07", g); end
      // Clip on the same clock as a status read: pre-update status, ovf survives.
      read_cyc(1, 9'h0FF, 9'h000, 3'd0, 1, g, e);
      checks++;
      if (g !== 8'h01) begin errors++; $display("FAIL sat_race got=%h exp=01", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 1, g, e);
      checks++;
      if (g !== 8'h05) begin errors++; $display("FAIL sat_keep got=%h exp=05", g); end
   endtask

   task automatic test_buttons();
      logic [7:0] g, e;
      do_reset();
      send_pkt(9'h000, 9'h000, 3'b101);
      read_cyc(0, 9'd0, 9'd0, 3'd0, 0, g, e);
      checks++;
      if (g !== 8'h50) begin errors++; $display("FAIL btn_rd got=%h exp=50", g); end
      checks++;
      if (bus.dout !== 8'hFF) begin errors++; $display("FAIL btn_sel_low got=%h exp=ff", bus.dout); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 6, g, e);
      checks++;
      if (g !== 8'hFF) begin errors++; $display("FAIL btn_addr6 got=%h exp=ff", g); end
   endtask

   task automatic test_sel_held();
      logic [7:0] g, e;
      do_reset();
      send_pkt(9'h014, 9'h000, 3'd0);
      bus.sel = 1'b1;
      bus.addr = 3'd2;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus.dout !== 8'h07) begin errors++; $display("FAIL held_%0d got=%h exp=07", i, bus.dout); end
      end
      e = 8'(model_cycle(0, 0, 0, 0, 1, 2));
      bus.sel = 1'b0;
      step();
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h07) begin errors++; $display("FAIL held_after got=%h exp=07", g); end
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h06) begin errors++; $display("FAIL held_last got=%h exp=06", g); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] g, e;
      do_reset();
      send_pkt(9'h014, 9'h000, 3'd0);
      bus.sel = 1'b1;
      bus.addr = 3'd2;
      step();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.dout !== 8'hFF) begin errors++; $display("FAIL midrst_dout got=%h exp=ff", bus.dout); end
      bus.sel = 1'b0;
      step();
      reset = 1'b0;
      step();
      m_x = 0; m_y = 0; m_btn = 0; m_ovf = 0;
      read_cyc(0, 9'd0, 9'd0, 3'd0, 2, g, e);
      checks++;
      if (g !== 8'h00) begin errors++; $display("FAIL midrst_acc got=%h exp=00", g); end
   endtask

   task automatic test_random();
      logic [7:0] g, e;
      logic [8:0] x9, y9;
      int op, a;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 2);
         x9 = 9'($urandom);
         y9 = 9'($urandom);
         a  = $urandom_range(0, 7);
         if (op == 0) begin
            send_pkt(x9, y9, 3'($urandom));
         end else begin
            read_cyc(op == 2, x9, y9, 3'($urandom & 7), a, g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL rand_%0d addr=%0d got=%h exp=%h", i, a, g, e); end
            checks++;
            if (bus.dout !== 8'hFF) begin errors++; $display("FAIL rand_idle_%0d got=%h exp=ff", i, bus.dout); end
         end
      end
   endtask

   initial begin
      bus.ps2_mouse = '0;
      bus.sel = 1'b0;
      bus.addr = 3'd0;
      test_reset();
      test_drain();
      test_y();
      test_same_clock();
      test_saturate();
      test_buttons();
      test_sel_held();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplay_mouse_acc.md
Name: multiplay_mouse_acc

Overview:
Accumulating mouse controller for the Multiplay interface port block. It integrates PS/2 mouse packets into signed X/Y accumulators and answers CPU reads with nibble-clamped deltas. Each read drains only the delivered amount, so motion larger than one read's step range is kept rather than lost. It sits between the HPS ps2_mouse bus and the I/O decode that drives sel/addr.

Parameters:
ACC_W, 12, accumulator width in bits, signed two's complement, minimum 5.
STEP_MAX, 7, largest positive delta returned per read; the most negative delta is -(STEP_MAX+1).

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_mouse  in  25  [24] packet toggle, [23:16] Y low byte, [15:8] X low byte, [5] Y sign, [4] X sign, [2:0] buttons
sel  in  1  port select; a read is triggered on its rising edge
addr  in  3  register index
dout  out  8  read data

Behaviour:
- All state is registered on clk_sys. Reset is asynchronous and active-high; it clears everything listed below.
- Reset values: acc_x=acc_y=0, btn=0, ovf=0, dout=8'hFF, old_sel=0, primed=0.
- Priming: on the first clock after reset release, only old_status<=ps2_mouse[24] is loaded and primed<=1. No packet is taken on that clock, so no spurious packet follows reset.
- Packet event: primed & (ps2_mouse[24] != old_status).
  - dx = 9-bit signed {[4],[15:8]}.
  - dy = negation of the 9-bit signed {[5],[23:16]}, so screen Y grows downward.
  - btn <= [2:0].
- Accumulation: acc <= sat(acc + delta), saturating at -2^(ACC_W-1) and 2^(ACC_W-1)-1. If saturation clips a value, ovf <= 1.
- Read event: ~old_sel & sel. old_sel <= sel every clock. dout is registered on the same edge that detects the event, so data is valid one clock after sel is first sampled high.
- Register map on a read event:
  - addr 0: {1'b0, btn, 4'b0000}.
  - addr 1: {5'b0, ovf, acc_y!=0, acc_x!=0}; ovf then clears.
  - addr 2: take_x = clamp(acc_x, -(STEP_MAX+1), STEP_MAX); dout = take_x sign-extended to 8 bits; acc_x <= acc_x - take_x.
  - addr 3: same as addr 2 for Y.
  - addr 4..7: 8'hFF.
- While sel=0, dout <= 8'hFF every clock. This has priority over nothing else, because no read can occur while sel is low.
- Packet and read of the same axis on the same clock: take is computed from the pre-update acc. New acc = sat(acc - take + delta). A read of the other axis is independent.
- A packet on the same clock as an addr 1 read: the status returned reflects pre-update state. An ovf raised by this packet stays set; it wins over the clear.
- sel held high: only one read event occurs, and dout holds its value.
- Reset mid-read: dout returns to FF immediately. The accumulators are lost. Priming repeats after release.
- A zero accumulator reads 8'h00. Reads never drive acc past zero; draining is monotonic toward 0.

Test Plan:
- Reset with ps2_mouse[24]=1 held, release -> no accumulation. A read of addr 2 returns 8'h00 and addr 1 returns 8'h00.
- Packet X=+20 (sign 0, byte 8'h14), then four addr 2 reads -> 8'h07, 8'h07, 8'h06, 8'h00. Addr 1 bit0 reads 1 before the third read and 0 after it.
- Packet Y byte 8'h05 with sign 0, then an addr 3 read -> 8'hFB (-5). A second read -> 8'h00.
- Packet X=-3 on the same clock as an addr 2 read with acc_x=10 -> dout 8'h07 and acc_x becomes 0. The next read returns 8'h00.
- Twenty packets of X=+255 with ACC_W=12 -> acc_x saturates at 2047. Addr 1 reads 8'h05 (ovf set, X nonzero); a second addr 1 read shows bit2 = 0.
- Buttons [2:0]=3'b101 in a packet, then an addr 0 read -> 8'h50. With sel low, dout = 8'hFF. An addr 6 read -> 8'hFF.
